// File: rtl/esp32_boot_pkg.sv
// Shared state encoding and FTDI modem-line decode for the ESP32 boot sequencer.
package esp32_boot_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_STRAP   = 2'd2,
    ST_RELEASE = 2'd3
  } boot_state_t;

  // Returns {want_en, want_io0} from the raw (synchronised) ndtr/nrts levels.
  function automatic logic [1:0] decode_modem(input logic dtr, input logic rts);
    case ({dtr, rts})
      2'b10:   return 2'b01;
      2'b01:   return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/esp32_boot_sequencer_sync_ff.sv
// Multi-stage synchroniser for asynchronous inputs with a configurable reset value.
module sync_ff #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/esp32_boot_sequencer.sv
// Clocked DTR/RTS to EN/GPIO0 sequencer: minimum EN-low time, timed boot-strap window.
// state    | meaning
// RUN      | ESP32 running, SPI mux owns sd_d
// HOLD     | EN low, counting minimum low time
// STRAP    | EN high, GPIO0/GPIO2/GPIO12 straps held for the window
// RELEASE  | single cycle handing sd_d back before RUN
module esp32_boot_sequencer
  import esp32_boot_pkg::*;
#(
  parameter int C_sync_stages     = 2,
  parameter int C_en_min_cycles   = 2500,
  parameter int C_strap_hold_bits = 17
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic       ftdi_ndtr,
  input  logic       ftdi_nrts,
  input  logic       btn_boot_n,
  output logic       wifi_en,
  output logic       wifi_gpio0,
  output logic       strap_oe,
  output logic       strap_gpio2,
  output logic [1:0] state_o,
  output logic       flash_entry,
  output logic [7:0] boot_count
);

  localparam int EN_W  = $clog2(C_en_min_cycles + 1);
  localparam int CNT_W = (EN_W > C_strap_hold_bits) ? EN_W : C_strap_hold_bits;
  localparam logic [CNT_W-1:0] EN_TC    = CNT_W'(C_en_min_cycles);
  localparam logic [CNT_W-1:0] STRAP_TC = CNT_W'((64'd1 << C_strap_hold_bits) - 64'd1);

  logic [2:0]       sync_q;
  logic             want_en, want_io0, btn_sync;
  boot_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             entry;

  sync_ff #(.WIDTH(3), .STAGES(C_sync_stages), .RST_VAL(3'b111)) u_sync (
    .clk   (clk_25mhz),
    .reset (reset),
    .d     ({ftdi_ndtr, ftdi_nrts, btn_boot_n}),
    .q     (sync_q)
  );

  assign {want_en, want_io0} = decode_modem(sync_q[2], sync_q[1]);
  assign btn_sync = sync_q[0];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    entry     = 1'b0;
    case (state)
      ST_RUN: begin
        if (!want_en) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt == EN_TC && want_en) begin
          cnt_nxt = '0;
          if (!want_io0 || !btn_sync) begin
            state_nxt = ST_STRAP;
            entry     = 1'b1;
          end else begin
            state_nxt = ST_RELEASE;
          end
        end else if (cnt != EN_TC) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_STRAP: begin
        // Abort beats timeout so a new reset request is never lost.
        if (!want_en) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end else if (cnt == STRAP_TC) begin
          state_nxt = ST_RELEASE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        state_nxt = want_en ? ST_RUN : ST_HOLD;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = ST_HOLD;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state       <= ST_HOLD;
      cnt         <= '0;
      wifi_en     <= 1'b0;
      wifi_gpio0  <= 1'b1;
      strap_oe    <= 1'b1;
      flash_entry <= 1'b0;
      boot_count  <= 8'd0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      flash_entry <= entry;
      if (entry && boot_count != 8'hFF) boot_count <= boot_count + 8'd1;
      case (state_nxt)
        ST_HOLD: begin
          wifi_en    <= 1'b0;
          wifi_gpio0 <= want_io0 & btn_sync;
          strap_oe   <= 1'b1;
        end
        ST_STRAP: begin
          wifi_en    <= 1'b1;
          wifi_gpio0 <= 1'b0;
          strap_oe   <= 1'b1;
        end
        default: begin
          wifi_en    <= 1'b1;
          wifi_gpio0 <= btn_sync;
          strap_oe   <= 1'b0;
        end
      endcase
    end
  end

  // GPIO2 strap is only ever driven low; strap_oe decides whether it reaches the pin.
  assign strap_gpio2 = 1'b0;
  assign state_o     = state;

endmodule
